shift_add_multiplier: RTL and testbench



---
 rtl/mul_pkg.sv | 14 +
 rtl/shift_add_multiplier_adder.sv | 23 ++
 rtl/shift_add_multiplier.sv | 130 +++++++++++++
 tb/tb_shift_add_multiplier.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding and
// the iteration-counter width helper.
package mul_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter must hold values 0..width, so one bit more than clog2.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// WIDTH-bit ripple-carry adder producing a WIDTH+1-bit sum (carry-out in MSB).
module RippleCarryAdder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   s
);

  always_comb begin : ripple
    logic carry;
    // NOTE: blocking assignments here on purpose: carry is a combinational
    // temporary that must update within the same pass of the loop.
    carry = 1'b0;
    s     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    s[WIDTH] = carry;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned shift-add multiplier with start/busy/done handshake.
// Optional early termination on exhausted multiplier bits: SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]           state_q,   state_d;
  logic [WIDTH-1:0]     mcand_q,   mcand_d;
  logic [WIDTH-1:0]     mq_q,      mq_d;
  logic [WIDTH-1:0]     acc_q,     acc_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   next_prod;
  logic [2*WIDTH-1:0]   final_prod;
  logic                 last_iter;

  assign addend = mq_q[0] ? mcand_q : '0;

  RippleCarryAdder #(.WIDTH(WIDTH)) u_adder (
    .a (acc_q),
    .b (addend),
    .s (sum)
  );

  // {acc, mq} after this iteration: carry-out lands in the acc MSB.
  assign next_prod = {sum, mq_q[WIDTH-1:1]};

`ifdef SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] rem_shift;

  // Once no multiplier bits remain, the outstanding iterations would only
  // shift, so apply all of them at once.
  assign last_iter  = (cnt_q == LAST_CNT) || ((shadow_q >> 1) == '0);
  assign rem_shift  = LAST_CNT - cnt_q;
  assign final_prod = next_prod >> rem_shift;
`else
  assign last_iter  = (cnt_q == LAST_CNT);
  assign final_prod = next_prod;
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    mcand_d   = mcand_q;
    mq_d      = mq_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN
    shadow_d  = shadow_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          mq_d    = b;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN
          shadow_d = b;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = next_prod[2*WIDTH-1:WIDTH];
        mq_d  = next_prod[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN
        shadow_d = shadow_q >> 1;
`endif
        if (last_iter) begin
          product_d = final_prod;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mq_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN
      shadow_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mq_q      <= mq_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN
      shadow_q  <= shadow_d;
`endif
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed scenarios plus a
// random sweep against an arithmetic reference (a*b, latency from b's MSB).
module tb_shift_add_multiplier;

  localparam int WIDTH  = 8;
  localparam int BUDGET = 4 * WIDTH;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [WIDTH-1:0]   a = '0;
  logic [WIDTH-1:0]   b = '0;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  // Value the product output is expected to hold between results.
  logic [2*WIDTH-1:0] held_product = '0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Edges after the accepting edge until done is seen high.
  function automatic int exp_latency(input logic [WIDTH-1:0] bv);
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN
    int top = 0;
    for (int i = 0; i < WIDTH; i++) if (bv[i]) top = i + 1;
    return (top == 0) ? 1 : top;
`else
    return (bv === bv) ? WIDTH : WIDTH;
`endif
  endfunction

  function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] av,
                                                 input logic [WIDTH-1:0] bv);
    longint unsigned pa = longint'(av);
    longint unsigned pb = longint'(bv);
    return (2*WIDTH)'(pa * pb);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One multiply from IDLE: checks busy/held product during the run, done
  // latency, result, and that the result stays put after done.
  task automatic do_mul(input string name, input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv);
    logic [2*WIDTH-1:0] want;
    int edges;
    want  = ref_mul(av, bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    tick();
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    edges = 0;
    while (!done && edges < BUDGET) begin
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy_in_run: got %b expected 1 (edge %0d)", name, busy, edges);
      end
      n_checks++;
      if (product !== held_product) begin
        n_fail++;
        $display("FAIL %s product_held: got %0d expected %0d", name, product, held_product);
      end
      tick();
      edges++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done_timeout: no done within %0d cycles", name, BUDGET);
      return;
    end
    n_checks++;
    if (edges != exp_latency(bv)) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d (a=%0d b=%0d)", name, edges,
               exp_latency(bv), av, bv);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_at_done: got %b expected 0", name, busy);
    end
    n_checks++;
    if (product !== want) begin
      n_fail++;
      $display("FAIL %s product: got %0d expected %0d (a=%0d b=%0d)", name, product, want, av, bv);
    end
    held_product = want;
    tick();
    n_checks++;
    if (done !== 1'b0 || product !== want) begin
      n_fail++;
      $display("FAIL %s after_done: done=%b product=%0d expected done=0 product=%0d",
               name, done, product, want);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++;
    if (product !== '0) begin n_fail++; $display("FAIL reset_product: got %0d expected 0", product); end
    rst_n = 1'b1;
    held_product = '0;
    tick();
  endtask

  task automatic test_basic;
    do_mul("basic_23x12", 8'd23, 8'd12);
    do_mul("max_255x255", 8'd255, 8'd255);
  endtask

  task automatic test_zero;
    do_mul("zero_a", 8'd0, 8'd200);
    do_mul("zero_b", 8'd200, 8'd0);
  endtask

  task automatic test_start_ignored;
    logic [WIDTH-1:0] b_first;
    int edges;
    // Pick a multiplier that keeps the unit busy past the fourth cycle.
    b_first = (exp_latency(8'd1) >= 4) ? 8'd1 : 8'h81;
    start = 1'b1;
    a = 8'd1;
    b = b_first;
    tick();
    start = 1'b0;
    edges = 0;
    tick(); edges++;
    tick(); edges++;
    start = 1'b1;
    a = 8'd35;
    b = 8'd71;
    tick(); edges++;
    start = 1'b0;
    while (!done && edges < BUDGET) begin
      tick();
      edges++;
    end
    n_checks++;
    if (done !== 1'b1 || edges != exp_latency(b_first)) begin
      n_fail++;
      $display("FAIL ignore_latency: done=%b edges=%0d expected edges=%0d", done, edges,
               exp_latency(b_first));
    end
    n_checks++;
    if (product !== ref_mul(8'd1, b_first)) begin
      n_fail++;
      $display("FAIL ignore_product: got %0d expected %0d", product, ref_mul(8'd1, b_first));
    end
    held_product = ref_mul(8'd1, b_first);
    // A start presented while done is high is dropped too.
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_in_done: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back;
    do_mul("b2b_35x71", 8'd35, 8'd71);
    do_mul("b2b_next", 8'd17, 8'd9);
  endtask

  task automatic test_mid_reset;
    int done_seen = 0;
    int busy_seen = 0;
    start = 1'b1;
    a = 8'd100;
    b = 8'd100;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: busy=%b done=%b product=%0d expected 0 0 0",
               busy, done, product);
    end
    held_product = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3 * WIDTH; i++) begin
      tick();
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    n_checks++;
    if (done_seen != 0 || busy_seen != 0) begin
      n_fail++;
      $display("FAIL midreset_no_done: done cycles=%0d busy cycles=%0d expected 0 0",
               done_seen, busy_seen);
    end
    do_mul("after_reset_3x8", 8'd3, 8'd8);
  endtask

  task automatic test_random;
    for (int i = 0; i < 1000; i++) begin
      do_mul("random", WIDTH'($urandom), WIDTH'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
